// File: rtl/instr_fetch_unit_if.sv
// Fetch-side bus bundle: instruction-memory read port plus the
// valid/ready instruction stream and redirect inputs from the datapath.
`timescale 1ns/1ps
interface instr_fetch_unit_if #(
    parameter int ADDR_W = 10
);
    logic              imem_en;
    logic [ADDR_W-1:0] imem_addr;
    logic [31:0]       imem_rdata;
    logic [31:0]       instr;
    logic [31:0]       instr_pc;
    logic [31:0]       instr_pc_plus4;
    logic              instr_valid;
    logic              instr_ready;
    logic              branch_taken;
    logic              jump;

    modport master (
        output imem_en, imem_addr, instr, instr_pc, instr_pc_plus4, instr_valid,
        input  imem_rdata, instr_ready, branch_taken, jump
    );

    modport slave (
        input  imem_en, imem_addr, instr, instr_pc, instr_pc_plus4, instr_valid,
        output imem_rdata, instr_ready, branch_taken, jump
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// Instruction fetch stage: owns the PC, issues one-cycle-latency reads to
// the instruction memory, buffers returned words in a 2-entry queue and
// resolves taken branches / jumps from the instruction being consumed.
`timescale 1ns/1ps
module instr_fetch_unit #(
    parameter int          ADDR_W   = 10,
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic               clk,
    input  logic               rst_n,
    instr_fetch_unit_if.master bus
);
    // fetch pointer and the read currently returning from memory
    logic [31:0] pc;
    logic        vld_p1;
    logic [31:0] tag_p1;

    // queue: head entry drives the outputs directly, tail holds the second word
    logic [1:0]  count;
    logic [31:0] head_instr;
    logic [31:0] head_pc;
    logic [31:0] tail_instr;
    logic [31:0] tail_pc;

    logic        deq;
    logic        redirect;
    logic        issue;
    logic        enq;
    logic [2:0]  credit;
    logic [31:0] head_pc_plus4;
    logic [31:0] target;

    assign deq           = (count != 2'd0) & bus.instr_ready;
    assign redirect      = deq & (bus.jump | bus.branch_taken);
    // slots already committed next cycle: queued words plus the returning read
    assign credit        = {1'b0, count} + {2'b00, vld_p1} - {2'b00, deq};
    // rst_n gate keeps the read strobe low for the whole time reset is held
    assign issue         = rst_n & ~redirect & (credit < 3'd2);
    // a word returning in the redirect cycle belongs to the wrong path
    assign enq           = vld_p1 & ~redirect;
    assign head_pc_plus4 = head_pc + 32'd4;

    assign bus.imem_en        = issue;
    assign bus.imem_addr      = pc[ADDR_W+1:2];
    assign bus.instr          = head_instr;
    assign bus.instr_pc       = head_pc;
    assign bus.instr_pc_plus4 = head_pc_plus4;
    assign bus.instr_valid    = (count != 2'd0);

    // Redirect target of the head instruction; jump wins over branch.
    always_comb begin
        if (bus.jump) begin
            target = {head_pc_plus4[31:28], head_instr[25:0], 2'b00};
        end else begin
            target = head_pc_plus4 + {{14{head_instr[15]}}, head_instr[15:0], 2'b00};
        end
    end

    // Control state: PC, in-flight flag, queue occupancy and the visible head.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            vld_p1     <= 1'b0;
            count      <= 2'd0;
            head_instr <= 32'd0;
            head_pc    <= 32'd0;
        end else begin
            vld_p1 <= issue;
            if (redirect) begin
                pc <= target;
            end else if (issue) begin
                pc <= pc + 32'd4;
            end

            if (redirect) begin
                count <= 2'd0;
            end else begin
                case (count)
                    2'd0: begin
                        if (enq) begin
                            head_instr <= bus.imem_rdata;
                            head_pc    <= tag_p1;
                            count      <= 2'd1;
                        end
                    end
                    2'd1: begin
                        if (deq && enq) begin
                            head_instr <= bus.imem_rdata;
                            head_pc    <= tag_p1;
                        end else if (deq) begin
                            count <= 2'd0;
                        end else if (enq) begin
                            count <= 2'd2;
                        end
                    end
                    2'd2: begin
                        if (deq) begin
                            head_instr <= tail_instr;
                            head_pc    <= tail_pc;
                            if (!enq) begin
                                count <= 2'd1;
                            end
                        end
                    end
                    default: count <= 2'd0;
                endcase
            end
        end
    end

    // Data-only registers: read tag and the tail slot need no reset.
    always_ff @(posedge clk) begin
        if (issue) begin
            tag_p1 <= pc;
        end
        if (enq && (((count == 2'd1) && !deq) || ((count == 2'd2) && deq))) begin
            tail_instr <= bus.imem_rdata;
            tail_pc    <= tag_p1;
        end
    end

    // Credit accounting must never let a returning word land on a full queue.
    overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
        !(enq && !deq && (count == 2'd2)));
endmodule

// File: tb/tb_instr_fetch_unit.sv
// Self-checking bench for instr_fetch_unit: directed reset / branch / jump /
// backpressure steps followed by a randomized stream, all checked against a
// program-order model of the expected instruction sequence.
`timescale 1ns/1ps
module tb_instr_fetch_unit;
    localparam int          ADDR_W   = 10;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    instr_fetch_unit_if #(.ADDR_W(ADDR_W)) bus();

    instr_fetch_unit #(.ADDR_W(ADDR_W), .RESET_PC(RESET_PC)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // synchronous instruction memory, one-cycle read latency
    logic [31:0] mem [0:(1<<ADDR_W)-1];
    always @(posedge clk) begin
        if (bus.imem_en) bus.imem_rdata <= mem[bus.imem_addr];
    end

    int          vectors     = 0;
    int          miscompares = 0;
    logic [31:0] exp_pc;
    logic        hold_chk;
    logic [31:0] prev_instr;
    logic [31:0] prev_pc;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // One clock: drive inputs, check hold stability and any consumed word
    // against the program-order model, then advance to the next falling edge.
    task automatic cyc(input logic rdy, input logic br, input logic jp);
        logic [31:0] w;
        bus.instr_ready  = rdy;
        bus.branch_taken = br;
        bus.jump         = jp;
        if (hold_chk) begin
            check("hold_valid", {31'b0, bus.instr_valid}, 32'd1);
            check("hold_instr", bus.instr, prev_instr);
            check("hold_pc", bus.instr_pc, prev_pc);
        end
        if (bus.instr_valid && rdy) begin
            w = mem[exp_pc[ADDR_W+1:2]];
            check("instr_pc", bus.instr_pc, exp_pc);
            check("instr", bus.instr, w);
            check("instr_pc_plus4", bus.instr_pc_plus4, exp_pc + 32'd4);
            if (jp)      exp_pc = {exp_pc[31:28] + {3'b0, (exp_pc[27:2] == 26'h3FF_FFFF)}, w[25:0], 2'b00};
            else if (br) exp_pc = exp_pc + 32'd4 + {{14{w[15]}}, w[15:0], 2'b00};
            else         exp_pc = exp_pc + 32'd4;
        end
        hold_chk   = bus.instr_valid && !rdy;
        prev_instr = bus.instr;
        prev_pc    = bus.instr_pc;
        @(negedge clk);
    endtask

    task automatic wait_valid(output int n);
        n = 0;
        while (!bus.instr_valid && n < 10) begin
            cyc(1'b1, 1'b0, 1'b0);
            n++;
        end
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_imem_en"}, {31'b0, bus.imem_en}, 32'd0);
        check({tag, "_valid"}, {31'b0, bus.instr_valid}, 32'd0);
        check({tag, "_instr"}, bus.instr, 32'd0);
        check({tag, "_pc"}, bus.instr_pc, 32'd0);
        check({tag, "_pc4"}, bus.instr_pc_plus4, 32'd4);
    endtask

    initial begin
        int   n;
        logic r, b, j;
        for (int k = 0; k < (1 << ADDR_W); k++) mem[k] = 32'hA000_0000 + 32'(k);
        mem[4] = 32'h1000_FFFC;   // pc 0x10: backward branch to 0x04
        mem[8] = 32'h0800_0040;   // pc 0x20: jump to 0x100
        rst_n            = 1'b0;
        bus.instr_ready  = 1'b0;
        bus.branch_taken = 1'b0;
        bus.jump         = 1'b0;
        hold_chk         = 1'b0;
        prev_instr       = 32'd0;
        prev_pc          = 32'd0;
        exp_pc           = RESET_PC;

        // reset values, then release and measure first-valid latency
        @(negedge clk);
        @(negedge clk);
        check_reset_outputs("reset");
        rst_n = 1'b1;
        wait_valid(n);
        check("reset_latency", 32'(n), 32'd2);

        // stream 0x00..0x0C back to back
        for (int i = 0; i < 4; i++) begin
            check("stream_valid", {31'b0, bus.instr_valid}, 32'd1);
            cyc(1'b1, 1'b0, 1'b0);
        end

        // backward branch at 0x10 -> 0x04, three cycles to the target
        check("br_head_valid", {31'b0, bus.instr_valid}, 32'd1);
        cyc(1'b1, 1'b1, 1'b0);
        wait_valid(n);
        check("branch_latency", 32'(n + 1), 32'd3);
        for (int i = 0; i < 2; i++) begin
            check("post_br_valid", {31'b0, bus.instr_valid}, 32'd1);
            cyc(1'b1, 1'b0, 1'b0);
        end

        // backpressure with branch_taken held: no redirect, fetch stops
        for (int i = 0; i < 5; i++) begin
            bus.instr_ready  = 1'b0;
            bus.branch_taken = 1'b1;
            #1;
            check("stall_imem_en", {31'b0, bus.imem_en}, 32'd0);
            cyc(1'b0, 1'b1, 1'b0);
        end
        for (int i = 0; i < 5; i++) begin
            check("resume_valid", {31'b0, bus.instr_valid}, 32'd1);
            cyc(1'b1, 1'b0, 1'b0);
        end

        // jump with branch also asserted at 0x20 -> 0x100
        check("jmp_head_pc", bus.instr_pc, 32'h20);
        cyc(1'b1, 1'b1, 1'b1);
        wait_valid(n);
        check("jump_latency", 32'(n + 1), 32'd3);

        // randomized ready / branch / jump traffic
        for (int i = 0; i < 400; i++) begin
            r = ($urandom_range(0, 99) < 75);
            b = ($urandom_range(0, 99) < 10);
            j = ($urandom_range(0, 99) < 5);
            cyc(r, b, j);
        end

        // reset in the middle of streaming with a read outstanding
        for (int i = 0; i < 4; i++) cyc(1'b1, 1'b0, 1'b0);
        bus.instr_ready = 1'b0;
        rst_n           = 1'b0;
        hold_chk        = 1'b0;
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        @(negedge clk);
        exp_pc = RESET_PC;
        rst_n  = 1'b1;
        wait_valid(n);
        check("restart_latency", 32'(n), 32'd2);
        for (int i = 0; i < 4; i++) begin
            check("restart_valid", {31'b0, bus.instr_valid}, 32'd1);
            cyc(1'b1, 1'b0, 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
